// File: rtl/lifo_stream_reverser.sv
// Frame reverser: pushes each framed input stream into an external LIFO, then pops it out reversed.
// Optional statistics counters are enabled with `define LIFO_REV_STATS_EN.
module lifo_stream_reverser #(
  parameter int DW    = 8,
  parameter int CNT_W = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          lifo_wn,
  output logic          lifo_rn,
  output logic [DW-1:0] lifo_din,
  input  logic [DW-1:0] lifo_dout,
  input  logic          lifo_full,
  input  logic          lifo_empty,
  output logic          trunc,
  output logic          err
`ifdef LIFO_REV_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   beat_cnt
`endif
);

  typedef enum logic [2:0] {FILL, DISCARD, POP, CAPT, OUT} state_t;

  state_t          state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic            err_nx;
  logic            m_valid_nx, m_last_nx;
  logic [DW-1:0]   m_data_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FILL;
      cnt     <= '0;
      err     <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      err     <= err_nx;
      m_valid <= m_valid_nx;
      m_last  <= m_last_nx;
      m_data  <= m_data_nx;
    end
  end

  // Strobes are combinational so a push lands in the same cycle the beat is accepted.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    err_nx     = err;
    m_valid_nx = m_valid;
    m_last_nx  = m_last;
    m_data_nx  = m_data;
    s_ready    = 1'b0;
    lifo_wn    = 1'b0;
    lifo_rn    = 1'b0;
    trunc      = 1'b0;
    lifo_din   = s_data;
    if (!reset) begin
      case (state)
        FILL: begin
          s_ready = !lifo_full;
          if (lifo_full) begin
            trunc    = 1'b1;
            state_nx = DISCARD;
          end else if (s_valid) begin
            lifo_wn = 1'b1;
            cnt_nx  = cnt + CNT_W'(1);
            if (s_last) state_nx = POP;
          end
        end
        DISCARD: begin
          s_ready = 1'b1;
          if (s_valid && s_last) state_nx = POP;
        end
        POP: begin
          if (cnt == '0) begin
            state_nx = FILL;
          end else if (lifo_empty) begin
            err_nx   = 1'b1;
            cnt_nx   = '0;
            state_nx = FILL;
          end else begin
            lifo_rn  = 1'b1;
            state_nx = CAPT;
          end
        end
        CAPT: begin
          m_data_nx  = lifo_dout;
          m_valid_nx = 1'b1;
          m_last_nx  = (cnt == CNT_W'(1));
          cnt_nx     = cnt - CNT_W'(1);
          state_nx   = OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid_nx = 1'b0;
            state_nx   = m_last ? FILL : POP;
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

`ifdef LIFO_REV_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      beat_cnt  <= '0;
    end else if (m_valid && m_ready) begin
      beat_cnt <= beat_cnt + 16'd1;
      if (m_last) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_stream_reverser.sv
// Self-checking bench for lifo_stream_reverser with a 7-deep LIFO model and a reversal reference model.
module tb_lifo_stream_reverser;

  typedef logic [7:0] byte_q_t[$];
  typedef logic [8:0] beat_q_t[$];

  logic       clock = 1'b0;
  logic       reset, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [7:0] s_data, m_data, lifo_din, lifo_dout;
  logic       lifo_wn, lifo_rn, lifo_full, lifo_empty, trunc, err;
`ifdef LIFO_REV_STATS_EN
  logic [15:0] frame_cnt, beat_cnt;
`endif

  int errors = 0;
  int checks = 0;
  beat_q_t out_q;
  int  trunc_n = 0, conflict_n = 0, lat_err = 0;
  bit  rn_d1 = 0, rn_d2 = 0;
  logic force_empty = 1'b0;
  bit  done;

  // LIFO model: capacity 7, pop data registered
  logic [7:0] mem [0:6];
  int sp = 0;
  assign lifo_full  = (sp == 7);
  assign lifo_empty = (sp == 0) || force_empty;

  always @(posedge clock) begin
    if (reset) sp <= 0;
    else if (lifo_wn && sp < 7) begin
      mem[sp] <= lifo_din;
      sp <= sp + 1;
    end else if (lifo_rn && sp > 0) begin
      lifo_dout <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  always #5 clock = ~clock;

  lifo_stream_reverser #(.DW(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .lifo_wn(lifo_wn), .lifo_rn(lifo_rn), .lifo_din(lifo_din), .lifo_dout(lifo_dout),
    .lifo_full(lifo_full), .lifo_empty(lifo_empty), .trunc(trunc), .err(err)
`ifdef LIFO_REV_STATS_EN
    , .frame_cnt(frame_cnt), .beat_cnt(beat_cnt)
`endif
  );

  // Inputs change at posedge+1, so values seen at negedge are those at the next edge.
  always @(negedge clock) begin
    if (reset) begin
      rn_d1 = 0;
      rn_d2 = 0;
    end else begin
      if (m_valid && m_ready) out_q.push_back({m_last, m_data});
      if (trunc) trunc_n++;
      if (lifo_wn && lifo_rn) conflict_n++;
      if (rn_d2 && !m_valid) lat_err++;
      rn_d2 = rn_d1;
      rn_d1 = lifo_rn;
    end
  end

  // Reference: first min(n,7) bytes survive, emitted newest first, last flag on the oldest.
  function automatic beat_q_t ref_reverse(input byte_q_t d);
    beat_q_t r;
    int k = (d.size() > 7) ? 7 : d.size();
    for (int i = k - 1; i >= 0; i--) r.push_back({(i == 0) ? 1'b1 : 1'b0, d[i]});
    return r;
  endfunction

  task automatic send_frame(input byte_q_t d, input int gap_max);
    for (int i = 0; i < d.size(); i++) begin
      int unsigned g;
      bit acc;
      int t;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      s_valid = 1'b0;
      repeat (g) begin @(posedge clock); #1; end
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = (i == d.size() - 1);
      acc = 0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clock);
        acc = s_ready;
        @(posedge clock); #1;
        t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout beat=%0d got=no_accept required=accept", i);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (out_q.size() < n && t < 400) begin
      @(posedge clock); #1;
      t++;
    end
    if (out_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_out got=%0d required=%0d", out_q.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    checks++;
    if ({m_valid, m_last, m_data, lifo_wn, lifo_rn, trunc, err, s_ready} !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0",
               {m_valid, m_last, m_data, lifo_wn, lifo_rn, trunc, err, s_ready});
    end
    s_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_fill_ready got=%b required=1", s_ready);
    end
  endtask

  task automatic test_basic;
    byte_q_t d = '{8'h11, 8'h22, 8'h33};
    beat_q_t exp;
    m_ready = 1'b1; out_q.delete(); trunc_n = 0;
    send_frame(d, 0);
    wait_out(3);
    exp = ref_reverse(d);
    checks++;
    if (out_q.size() !== exp.size()) begin
      errors++; $display("FAIL basic_len got=%0d required=%0d", out_q.size(), exp.size());
    end else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin
        errors++; $display("FAIL basic_beat%0d got=%h required=%h", i, out_q[i], exp[i]);
      end
    end
    checks++;
    if (trunc_n !== 0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL basic_idle got=trunc%0d/ready%b required=trunc0/ready1", trunc_n, s_ready);
    end
  endtask

  task automatic test_full7;
    byte_q_t d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    beat_q_t exp;
    m_ready = 1'b1; out_q.delete(); trunc_n = 0;
    send_frame(d, 0);
    checks++;
    if (lifo_full !== 1'b1) begin
      errors++; $display("FAIL full7_flag got=%b required=1", lifo_full);
    end
    wait_out(7);
    exp = ref_reverse(d);
    checks++;
    if (out_q.size() !== exp.size()) begin
      errors++; $display("FAIL full7_len got=%0d required=%0d", out_q.size(), exp.size());
    end else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin
        errors++; $display("FAIL full7_beat%0d got=%h required=%h", i, out_q[i], exp[i]);
      end
    end
    checks++;
    if (trunc_n !== 0) begin
      errors++; $display("FAIL full7_trunc got=%0d required=0", trunc_n);
    end
  endtask

  task automatic test_trunc9;
    byte_q_t d;
    beat_q_t exp;
    for (int i = 0; i < 9; i++) d.push_back(8'hA0 + 8'(i));
    m_ready = 1'b1; out_q.delete(); trunc_n = 0;
    send_frame(d, 0);
    wait_out(7);
    repeat (5) begin @(posedge clock); #1; end
    exp = ref_reverse(d);
    checks++;
    if (out_q.size() !== exp.size()) begin
      errors++; $display("FAIL trunc9_len got=%0d required=%0d", out_q.size(), exp.size());
    end else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin
        errors++; $display("FAIL trunc9_beat%0d got=%h required=%h", i, out_q[i], exp[i]);
      end
    end
    checks++;
    if (trunc_n !== 1) begin
      errors++; $display("FAIL trunc9_pulses got=%0d required=1", trunc_n);
    end
  endtask

  task automatic test_backpressure;
    byte_q_t d = '{8'h41, 8'h42, 8'h43};
    beat_q_t exp;
    logic [8:0] held;
    int t;
    m_ready = 1'b0; out_q.delete();
    send_frame(d, 0);
    t = 0;
    do begin @(negedge clock); t++; end while (!m_valid && t < 20);
    @(posedge clock); #1; m_ready = 1'b1;
    @(posedge clock); #1; m_ready = 1'b0;
    t = 0;
    do begin @(negedge clock); t++; end while (!m_valid && t < 20);
    held = {m_last, m_data};
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if ({m_valid, m_last, m_data, lifo_rn} !== {1'b1, held, 1'b0}) begin
        errors++;
        $display("FAIL stall_c%0d got=%h required=%h", c, {m_valid, m_last, m_data, lifo_rn},
                 {1'b1, held, 1'b0});
      end
    end
    @(posedge clock); #1; m_ready = 1'b1;
    wait_out(3);
    exp = ref_reverse(d);
    checks++;
    if (out_q.size() !== exp.size()) begin
      errors++; $display("FAIL stall_len got=%0d required=%0d", out_q.size(), exp.size());
    end else foreach (exp[i]) begin
      checks++;
      if (out_q[i] !== exp[i]) begin
        errors++; $display("FAIL stall_beat%0d got=%h required=%h", i, out_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_err;
    byte_q_t d = '{8'h55, 8'h66};
    m_ready = 1'b1; out_q.delete();
    send_frame(d, 0);
    force_empty = 1'b1;
    @(negedge clock);
    checks++;
    if (lifo_rn !== 1'b0) begin
      errors++; $display("FAIL err_no_pop got=%b required=0", lifo_rn);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if ({err, m_valid, s_ready} !== 3'b101) begin
        errors++; $display("FAIL err_sticky_c%0d got=%b required=101", c, {err, m_valid, s_ready});
      end
    end
    checks++;
    if (out_q.size() !== 0) begin
      errors++; $display("FAIL err_no_output got=%0d required=0", out_q.size());
    end
    @(posedge clock); #1;
    force_empty = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_reset_clear got=%b required=0", err);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_middrain;
    byte_q_t d = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    beat_q_t exp;
    int total = 0;
    m_ready = 1'b1; out_q.delete();
    send_frame(d, 0);
    wait_out(2);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({m_valid, m_last, m_data, lifo_wn, lifo_rn, trunc, err, s_ready} !== 14'h0) begin
      errors++;
      $display("FAIL middrain_reset got=%h required=0",
               {m_valid, m_last, m_data, lifo_wn, lifo_rn, trunc, err, s_ready});
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL middrain_fill got=%b required=1", s_ready);
    end
    for (int f = 0; f < 3; f++) begin
      d.delete();
      for (int i = 0; i <= f + 1; i++) d.push_back(8'(8'h70 + 8'(16 * f + i)));
      total += d.size();
      out_q.delete();
      send_frame(d, 1);
      wait_out(d.size());
      exp = ref_reverse(d);
      checks++;
      if (out_q !== exp) begin
        errors++; $display("FAIL middrain_frame%0d got=%p required=%p", f, out_q, exp);
      end
    end
`ifdef LIFO_REV_STATS_EN
    checks++;
    if (frame_cnt !== 16'd3 || beat_cnt !== 16'(total)) begin
      errors++; $display("FAIL stats got=%0d/%0d required=3/%0d", frame_cnt, beat_cnt, total);
    end
`endif
  endtask

  task automatic test_random;
    done = 0;
    conflict_n = 0; lat_err = 0;
    fork
      begin
        for (int f = 0; f < 25; f++) begin
          byte_q_t d;
          beat_q_t exp;
          int n = $urandom_range(1, 10);
          for (int i = 0; i < n; i++) d.push_back(8'($urandom));
          out_q.delete(); trunc_n = 0;
          send_frame(d, 2);
          exp = ref_reverse(d);
          wait_out(exp.size());
          checks++;
          if (out_q !== exp) begin
            errors++; $display("FAIL rand_frame%0d len=%0d got=%p required=%p", f, n, out_q, exp);
          end
          checks++;
          if (trunc_n !== ((n > 7) ? 1 : 0)) begin
            errors++; $display("FAIL rand_trunc%0d got=%0d required=%0d", f, trunc_n, (n > 7) ? 1 : 0);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clock); #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    checks++;
    if (conflict_n !== 0 || lat_err !== 0) begin
      errors++; $display("FAIL rand_strobes got=conflict%0d/latency%0d required=0/0", conflict_n, lat_err);
    end
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    test_reset();
    test_basic();
    test_full7();
    test_trunc9();
    test_backpressure();
    test_err();
    test_reset_middrain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
